// File: rtl/systolic_matmul_engine.sv
// -----------------------------------------------------------------------------
// systolic_matmul_engine
//
// Computes C = A x B (or C += A x B) for NxN matrices on an output-stationary
// NxN multiply-accumulate array. Operands are loaded in one transfer, skewed so
// that a[i][k] and b[k][j] meet in PE(i,j) at compute cycle k+i+j, and the
// accumulators are presented as the result once the wavefront has drained.
//
// Ports
//   i_clk          clock, all state updates on the rising edge
//   i_arst         synchronous active-high reset
//   i_a, i_b       operand matrices, indexed [row][col]
//   i_validInput   operand pair (and i_accumulate) valid this cycle
//   i_accumulate   1 = add product onto held C, 0 = clear C first
//   o_readyInput   engine accepts an operand pair this cycle
//   o_c            result matrix, indexed [row][col]
//   o_validResult  o_c holds a complete result
//   i_resultReady  consumer takes the result this cycle
//   o_busy         high while computing
// -----------------------------------------------------------------------------
module systolic_matmul_engine #(
  parameter int N      = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int SIGNED = 0
) (
  input  logic                                 i_clk,
  input  logic                                 i_arst,
  input  logic [N-1:0][N-1:0][DATA_W-1:0]      i_a,
  input  logic [N-1:0][N-1:0][DATA_W-1:0]      i_b,
  input  logic                                 i_validInput,
  input  logic                                 i_accumulate,
  output logic                                 o_readyInput,
  output logic [N-1:0][N-1:0][ACC_W-1:0]       o_c,
  output logic                                 o_validResult,
  input  logic                                 i_resultReady,
  output logic                                 o_busy
);

  // A row i / B column j is loaded with i (resp. j) leading zero slots, so the
  // longest skew line holds N-1 zeros followed by N operands.
  localparam int SLOTS = 2 * N - 1;
  localparam int CNT_W = $clog2(3 * N - 2);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(3 * N - 3);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COMPUTE,
    ST_DONE
  } state_e;

  // Full-width product, extended to the accumulator width. Operands are
  // extended to 2*DATA_W first so the low 2*DATA_W bits of the unsigned
  // multiply are the exact signed or unsigned product.
  function automatic logic [ACC_W-1:0] mac_product(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
    logic [2*DATA_W-1:0] a_ext;
    logic [2*DATA_W-1:0] b_ext;
    logic [2*DATA_W-1:0] prod;
    if (SIGNED != 0) begin
      a_ext = {{DATA_W{a[DATA_W-1]}}, a};
      b_ext = {{DATA_W{b[DATA_W-1]}}, b};
    end else begin
      a_ext = {{DATA_W{1'b0}}, a};
      b_ext = {{DATA_W{1'b0}}, b};
    end
    prod = a_ext * b_ext;
    if (SIGNED != 0) begin
      mac_product = ACC_W'($signed(prod));
    end else begin
      mac_product = ACC_W'(prod);
    end
  endfunction

  state_e                                state_q, state_d;
  logic [CNT_W-1:0]                      cnt_q, cnt_d;
  logic                                  valid_q, valid_d;
  logic                                  busy_q, busy_d;
  // Skew lines: slot 0 is the head that feeds the array edge.
  logic [N-1:0][SLOTS-1:0][DATA_W-1:0]   skew_a_q, skew_a_d;
  logic [N-1:0][SLOTS-1:0][DATA_W-1:0]   skew_b_q, skew_b_d;
  // Inter-PE operand registers; the last column/row forwards nowhere.
  logic [N-1:0][N-2:0][DATA_W-1:0]       a_pipe_q, a_pipe_d;
  logic [N-2:0][N-1:0][DATA_W-1:0]       b_pipe_q, b_pipe_d;
  logic [N-1:0][N-1:0][ACC_W-1:0]        acc_q, acc_d;

  logic [N-1:0][N-1:0][DATA_W-1:0]       a_in;
  logic [N-1:0][N-1:0][DATA_W-1:0]       b_in;
  logic [N-1:0][N-1:0][ACC_W-1:0]        prod;
  logic                                  accept;

  assign o_readyInput  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && i_resultReady);
  assign accept        = i_validInput && o_readyInput;
  assign o_validResult = valid_q;
  assign o_busy        = busy_q;
  assign o_c           = acc_q;

  // Operand routing: edge PEs read the skew heads, inner PEs read the
  // registered operand of their left / upper neighbour.
  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      if (j == 0) begin : g_a_edge
        assign a_in[i][j] = skew_a_q[i][0];
      end else begin : g_a_inner
        assign a_in[i][j] = a_pipe_q[i][j-1];
      end
      if (i == 0) begin : g_b_edge
        assign b_in[i][j] = skew_b_q[j][0];
      end else begin : g_b_inner
        assign b_in[i][j] = b_pipe_q[i-1][j];
      end
      assign prod[i][j] = mac_product(a_in[i][j], b_in[i][j]);
    end
  end

  // NOTE: every variable starts from its held value before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    skew_a_d = skew_a_q;
    skew_b_d = skew_b_q;
    a_pipe_d = a_pipe_q;
    b_pipe_d = b_pipe_q;
    acc_d    = acc_q;

    unique case (state_q)
      ST_COMPUTE: begin
        // Shift every skew line one slot toward the array, zero-filling.
        for (int i = 0; i < N; i++) begin
          skew_a_d[i] = skew_a_q[i] >> DATA_W;
          skew_b_d[i] = skew_b_q[i] >> DATA_W;
        end
        for (int i = 0; i < N; i++) begin
          for (int j = 0; j < N - 1; j++) begin
            a_pipe_d[i][j] = a_in[i][j];
          end
        end
        for (int i = 0; i < N - 1; i++) begin
          for (int j = 0; j < N; j++) begin
            b_pipe_d[i][j] = b_in[i][j];
          end
        end
        // Zero operands in unfilled slots make the product zero, so every PE
        // can accumulate unconditionally on every compute cycle.
        for (int i = 0; i < N; i++) begin
          for (int j = 0; j < N; j++) begin
            acc_d[i][j] = acc_q[i][j] + prod[i][j];
          end
        end
        if (cnt_q == LAST_CNT) begin
          state_d = ST_DONE;
          cnt_d   = '0;
          valid_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (i_resultReady) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end
      end
      ST_IDLE: begin
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Accept takes priority over the DONE -> IDLE hand-off so a new pair can
    // follow a consumed result with no idle cycle.
    if (accept) begin
      skew_a_d = '0;
      skew_b_d = '0;
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < N; k++) begin
          skew_a_d[i][k+i] = i_a[i][k];
          skew_b_d[i][k+i] = i_b[k][i];
        end
      end
      a_pipe_d = '0;
      b_pipe_d = '0;
      if (!i_accumulate) begin
        acc_d = '0;
      end
      state_d = ST_COMPUTE;
      cnt_d   = '0;
      valid_d = 1'b0;
      busy_d  = 1'b1;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      // NOTE: the skew lines, operand pipes and accumulators are reset too:
      // zero slots must contribute nothing and accumulate mode reads held C.
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      skew_a_q <= '0;
      skew_b_q <= '0;
      a_pipe_q <= '0;
      b_pipe_q <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      skew_a_q <= skew_a_d;
      skew_b_q <= skew_b_d;
      a_pipe_q <= a_pipe_d;
      b_pipe_q <= b_pipe_d;
      acc_q    <= acc_d;
    end
  end

endmodule

// File: tb/tb_systolic_matmul_engine.sv
// -----------------------------------------------------------------------------
// tb_systolic_matmul_engine
//
// Three engines share one set of inputs: unsigned/32-bit, signed/32-bit and
// unsigned/16-bit. They run in lock-step, so one handshake sequence exercises
// plain, signed and wrapping arithmetic. Expected matrices come from a
// reference model and travel through a scoreboard queue from accept to result.
// -----------------------------------------------------------------------------
module tb_systolic_matmul_engine;

  typedef logic [3:0][3:0][7:0]  mat_t;
  typedef logic [3:0][3:0][31:0] res32_t;
  typedef logic [3:0][3:0][15:0] res16_t;

  typedef struct packed {
    res32_t cu;
    res32_t cs;
    res16_t cw;
  } exp_t;

  logic   clk;
  logic   i_arst;
  mat_t   i_a;
  mat_t   i_b;
  logic   i_validInput;
  logic   i_accumulate;
  logic   i_resultReady;

  logic   ready_u, ready_s, ready_w;
  logic   valid_u, valid_s, valid_w;
  logic   busy_u, busy_s, busy_w;
  res32_t c_u, c_s;
  res16_t c_w;

  int     n_checks = 0;
  int     n_errors = 0;

  exp_t   sb_q[$];
  res32_t m_u, m_s;
  res16_t m_w;

  systolic_matmul_engine #(.N(4), .DATA_W(8), .ACC_W(32), .SIGNED(0)) u_dut (
    .i_clk(clk), .i_arst(i_arst), .i_a(i_a), .i_b(i_b),
    .i_validInput(i_validInput), .i_accumulate(i_accumulate),
    .o_readyInput(ready_u), .o_c(c_u), .o_validResult(valid_u),
    .i_resultReady(i_resultReady), .o_busy(busy_u)
  );

  systolic_matmul_engine #(.N(4), .DATA_W(8), .ACC_W(32), .SIGNED(1)) u_dut_s (
    .i_clk(clk), .i_arst(i_arst), .i_a(i_a), .i_b(i_b),
    .i_validInput(i_validInput), .i_accumulate(i_accumulate),
    .o_readyInput(ready_s), .o_c(c_s), .o_validResult(valid_s),
    .i_resultReady(i_resultReady), .o_busy(busy_s)
  );

  systolic_matmul_engine #(.N(4), .DATA_W(8), .ACC_W(16), .SIGNED(0)) u_dut_w (
    .i_clk(clk), .i_arst(i_arst), .i_a(i_a), .i_b(i_b),
    .i_validInput(i_validInput), .i_accumulate(i_accumulate),
    .o_readyInput(ready_w), .o_c(c_w), .o_validResult(valid_w),
    .i_resultReady(i_resultReady), .o_busy(busy_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs are driven and outputs sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_u = '0;
    m_s = '0;
    m_w = '0;
  endtask

  task automatic model_accept(input mat_t a, input mat_t b, input logic acc);
    longint su, ss;
    if (!acc) model_reset();
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        su = 0;
        ss = 0;
        for (int k = 0; k < 4; k++) begin
          su += longint'(a[r][k]) * longint'(b[k][c]);
          ss += longint'($signed(a[r][k])) * longint'($signed(b[k][c]));
        end
        m_u[r][c] = m_u[r][c] + 32'(su);
        m_s[r][c] = m_s[r][c] + 32'(ss);
        m_w[r][c] = m_w[r][c] + 16'(su);
      end
    end
    sb_q.push_back('{cu: m_u, cs: m_s, cw: m_w});
  endtask

  function automatic mat_t fill(input logic [7:0] v);
    mat_t m;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        m[r][c] = v;
    return m;
  endfunction

  function automatic mat_t rand_mat();
    mat_t m;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        m[r][c] = 8'($urandom_range(0, 255));
    return m;
  endfunction

  function automatic res32_t widen(input mat_t m);
    res32_t w;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        w[r][c] = {24'd0, m[r][c]};
    return w;
  endfunction

  // Present a pair (optionally taking a pending result on the same edge) and
  // check the engine enters COMPUTE.
  task automatic accept_pair(input mat_t a, input mat_t b, input logic acc, input logic take);
    i_a           = a;
    i_b           = b;
    i_accumulate  = acc;
    i_validInput  = 1'b1;
    i_resultReady = take;
    #1;
    check("ready_before_accept", ready_u, 1'b1);
    model_accept(a, b, acc);
    @(posedge clk);
    #1;
    i_validInput  = 1'b0;
    i_resultReady = 1'b0;
    i_accumulate  = 1'b0;
    check("valid_low_after_accept", valid_u, 1'b0);
    check("busy_after_accept", busy_u, 1'b1);
    check("ready_low_in_compute", ready_u, 1'b0);
  endtask

  // Wait (bounded) for the result; exp_lat is the number of edges still to
  // go from the current point.
  task automatic wait_result(input string tag, input int exp_lat);
    int   k = 0;
    bit   seen = 0;
    exp_t e;
    while (!seen && k < 16) begin
      tick();
      k++;
      if (valid_u) begin
        seen = 1;
      end else begin
        check({tag, "_ready_low"}, ready_u, 1'b0);
        check({tag, "_busy_high"}, busy_u, 1'b1);
      end
    end
    check({tag, "_latency"}, k, exp_lat);
    check({tag, "_valid_s"}, valid_s, 1'b1);
    check({tag, "_valid_w"}, valid_w, 1'b1);
    check({tag, "_busy_low"}, busy_u, 1'b0);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({tag, "_c_unsigned"}, c_u, e.cu);
      check({tag, "_c_signed"}, c_s, e.cs);
      check({tag, "_c_wrap16"}, c_w, e.cw);
    end
  endtask

  task automatic consume(input string tag);
    i_resultReady = 1'b1;
    tick();
    i_resultReady = 1'b0;
    check({tag, "_valid_cleared"}, valid_u, 1'b0);
    check({tag, "_ready_idle"}, ready_u, 1'b1);
    check({tag, "_busy_idle"}, busy_u, 1'b0);
  endtask

  initial begin
    mat_t   ident, bseq, ones, twos, ra, rb;
    res32_t hold;

    i_arst        = 1'b1;
    i_a           = '0;
    i_b           = '0;
    i_validInput  = 1'b0;
    i_accumulate  = 1'b0;
    i_resultReady = 1'b0;
    model_reset();
    tick();
    tick();
    i_arst = 1'b0;

    // Reset state.
    check("reset_ready", ready_u, 1'b1);
    check("reset_valid", valid_u, 1'b0);
    check("reset_busy", busy_u, 1'b0);
    check("reset_c", c_u, '0);
    check("reset_c_w", c_w, '0);

    // Identity x B gives B, result after 10 edges.
    ident = '0;
    for (int r = 0; r < 4; r++) begin
      ident[r][r] = 8'd1;
      for (int c = 0; c < 4; c++) bseq[r][c] = 8'(4 * r + c + 1);
    end
    accept_pair(ident, bseq, 1'b0, 1'b0);
    wait_result("ident", 10);
    check("ident_c_equals_b", c_u, widen(bseq));

    // Back-pressure: result must hold steady while not taken.
    hold = c_u;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("bp_valid_held", valid_u, 1'b1);
      check("bp_c_stable", c_u, hold);
    end

    // Take the result and accept the next pair on the same edge.
    ones = fill(8'd1);
    twos = fill(8'd2);
    accept_pair(ones, twos, 1'b0, 1'b1);
    wait_result("acc_clear", 10);
    check("acc_clear_elem", c_u[2][3], 32'd8);
    consume("acc_clear");

    // Accumulate onto the held result.
    accept_pair(ones, twos, 1'b1, 1'b0);
    wait_result("acc_add", 10);
    check("acc_add_elem", c_u[1][2], 32'd16);
    consume("acc_add");

    // Signed extremes.
    accept_pair(fill(8'h80), fill(8'h7F), 1'b0, 1'b0);
    wait_result("signed", 10);
    check("signed_elem", c_s[2][1], 32'hFFFF0200);
    consume("signed");

    // Wrap at 16 bits; valid/ready pulses during COMPUTE must be ignored.
    accept_pair(fill(8'hFF), fill(8'hFF), 1'b0, 1'b0);
    i_a           = rand_mat();
    i_b           = rand_mat();
    i_validInput  = 1'b1;
    i_resultReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("compute_ignores_valid", ready_u, 1'b0);
    end
    i_validInput  = 1'b0;
    i_resultReady = 1'b0;
    wait_result("wrap", 7);
    check("wrap_elem", c_w[3][0], 16'd63492);
    consume("wrap");

    // Random pair, then random accumulate on top of it.
    ra = rand_mat();
    rb = rand_mat();
    accept_pair(ra, rb, 1'b0, 1'b0);
    wait_result("rand0", 10);
    consume("rand0");
    ra = rand_mat();
    rb = rand_mat();
    accept_pair(ra, rb, 1'b1, 1'b0);
    wait_result("rand1", 10);
    consume("rand1");

    // Reset mid-COMPUTE while the counter is at 5.
    accept_pair(rand_mat(), rand_mat(), 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    i_arst = 1'b1;
    tick();
    i_arst = 1'b0;
    void'(sb_q.pop_back());
    model_reset();
    check("midrst_ready", ready_u, 1'b1);
    check("midrst_valid", valid_u, 1'b0);
    check("midrst_busy", busy_u, 1'b0);
    check("midrst_c", c_u, '0);
    check("midrst_c_s", c_s, '0);

    // Fresh accept after reset completes with normal latency.
    ra = rand_mat();
    rb = rand_mat();
    accept_pair(ra, rb, 1'b0, 1'b0);
    wait_result("post_reset", 10);
    consume("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
